test_end_responder: RTL and testbench
=====================================

# test_end_responder

DUT-side end-of-test responder, the counterpart of the bench-side watchdog that waits for an end-of-test notification or times out. It counts completed test steps and errors after a start pulse. It raises an end-of-test request with a pass/fail verdict when all steps finish, or when its own cycle budget expires. It holds that request until the bench acknowledges, so the bench can finish cleanly, or save/restore a checkpoint, before its own watchdog fires.

## Interface
- CYC_W, 32: width of the cycle counter.
- ERR_W, 16: width of the error counter; the counter saturates.
- MAX_CYC, 40000: cycle budget in RUN. Must be ≥1 and < 2^CYC_W.
- clk  in  1  Single clock; all logic is on its rising edge.
- rst  in  1  Reset, asynchronous and active-high.
- start  in  1  Begin a test; sampled only in IDLE and DONE.
- n_steps  in  16  Steps expected; sampled on the accepted start edge.
- step_done  in  1  One-cycle pulse per completed step; used only in RUN.
- step_err  in  1  Marks the same-cycle step_done as failed; ignored unless step_done=1.
- done_req  out  1  End-of-test request; held high until acknowledged.
- done_ack  in  1  Bench acknowledge; used only while done_req=1.
- pass  out  1  Verdict; valid while done_req=1 and in DONE.
- timeout  out  1  Set when the verdict came from budget expiry.
- busy  out  1  High in RUN and REPORT.
- err_cnt  out  ERR_W  Number of failed steps.
- cyc_cnt  out  CYC_W  Cycles spent in RUN.

## Operation
- FSM states: IDLE, RUN, REPORT, DONE. Encoding is free.
- IDLE, with start=1:
  - Latch n_steps; clear step count, err_cnt, cyc_cnt, pass and timeout.
  - Go to RUN, or straight to REPORT with pass=1 if n_steps=0.
- RUN, every cycle:
  - cyc_cnt += 1.
  - On step_done: step count += 1. If step_err=1, err_cnt += 1, saturating at 2^ERR_W−1.
  - Completion: the step count, including this cycle's step_done, equals the latched n_steps. Go to REPORT with pass = (err_cnt after this cycle's update == 0), timeout=0.
  - Else if cyc_cnt == MAX_CYC−1 on this edge: go to REPORT with pass=0, timeout=1.
  - If completion and budget expiry fall on the same edge, completion wins.
  - start is ignored in RUN.
- REPORT:
  - done_req=1.
  - On done_ack=1: go to DONE and clear done_req.
  - step_done and start are ignored.
- DONE:
  - pass, timeout, err_cnt and cyc_cnt hold.
  - start=1 behaves exactly as start in IDLE.
  - done_ack is ignored.
- Counters freeze outside RUN. Step count never exceeds n_steps.
- Reset mid-operation: everything returns to reset values immediately; an open done_req drops without any ack.

## Timing
- Reset values: state=IDLE, done_req=0, pass=0, timeout=0, busy=0, err_cnt=0, cyc_cnt=0.
- Accepted start at edge T:
  - busy=1 from T.
  - The first RUN cycle follows T; cyc_cnt reads 1 after the edge ending that cycle.
- Final step_done sampled at edge T: done_req=1, pass and timeout valid immediately after T.
- Budget expiry: done_req rises after exactly MAX_CYC RUN cycles, with cyc_cnt=MAX_CYC.
- done_ack sampled high at edge T: done_req=0 and busy=0 after T.
  - An ack held high into the same cycle done_req rises is accepted at the next edge. Minimum done_req width is 1 cycle.
- done_req, pass and timeout are registered outputs, with no combinational path from inputs.

## Test plan
- Normal pass:
  - Stimulus: n_steps=3, start, three clean step_done pulses 5 cycles apart, ack 2 cycles after done_req.
  - Required: done_req high for exactly 3 cycles, pass=1, timeout=0, err_cnt=0, cyc_cnt=11.
- Errors and saturation:
  - Stimulus: ERR_W=2, n_steps=5, all five step_done with step_err.
  - Required: err_cnt=3 (saturated), pass=0, timeout=0.
- Timeout:
  - Stimulus: MAX_CYC=8, n_steps=4, one step only.
  - Required: done_req rises after 8 RUN cycles, cyc_cnt=8, pass=0, timeout=1.
- Simultaneous completion and expiry:
  - Stimulus: MAX_CYC=4, n_steps=1, a clean step_done in the 4th RUN cycle.
  - Required: pass=1, timeout=0.
- Zero steps and restart from DONE:
  - Stimulus: n_steps=0, start.
  - Required: done_req is high the cycle after start. After ack, a second start with n_steps=2 clears err_cnt and cyc_cnt to 0 and re-enters RUN.
- Reset mid-REPORT:
  - Stimulus: assert rst while done_req=1, with no ack.
  - Required: done_req=0, state IDLE, all outputs at reset values. done_ack pulses after release are ignored.

Source files
------------

// File: rtl/test_end_responder.sv
`default_nettype none
// ============================================================================
// Module      : test_end_responder
// Description : Counts test steps and errors after a start pulse. Raises a
//               held end-of-test request with a pass/fail verdict.
// Revision    : 1.0 - initial release
// ============================================================================
module test_end_responder #(
    parameter int CYC_W   = 32,
    parameter int ERR_W   = 16,
    parameter int MAX_CYC = 40000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [15:0]      n_steps,
    input  logic             step_done,
    input  logic             step_err,
    output logic             done_req,
    input  logic             done_ack,
    output logic             pass,
    output logic             timeout,
    output logic             busy,
    output logic [ERR_W-1:0] err_cnt,
    output logic [CYC_W-1:0] cyc_cnt
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_run    = 2'd1;
    localparam logic [1:0] c_st_report = 2'd2;
    localparam logic [1:0] c_st_done   = 2'd3;

    localparam logic [ERR_W-1:0] c_err_max  = '1;
    localparam logic [CYC_W-1:0] c_cyc_last = CYC_W'(MAX_CYC - 1);

    logic [1:0]       r_state,    w_state;
    logic [15:0]      r_n_steps,  w_n_steps;
    logic [15:0]      r_step_cnt, w_step_cnt;
    logic [ERR_W-1:0] r_err_cnt,  w_err_cnt;
    logic [CYC_W-1:0] r_cyc_cnt,  w_cyc_cnt;
    logic             r_pass,     w_pass;
    logic             r_timeout,  w_timeout;
    logic             r_done_req, w_done_req;

    // Counter values including this cycle's step; the step count stays below
    // n_steps in RUN, so the increment cannot overflow.
    logic [15:0]      w_step_inc;
    logic [ERR_W-1:0] w_err_inc;

    assign w_step_inc = r_step_cnt + 16'(step_done);
    assign w_err_inc  = (step_done && step_err && (r_err_cnt != c_err_max))
                      ? r_err_cnt + ERR_W'(1) : r_err_cnt;

    always_comb begin
        w_state    = r_state;
        w_n_steps  = r_n_steps;
        w_step_cnt = r_step_cnt;
        w_err_cnt  = r_err_cnt;
        w_cyc_cnt  = r_cyc_cnt;
        w_pass     = r_pass;
        w_timeout  = r_timeout;
        w_done_req = r_done_req;
        case (r_state)
            c_st_idle, c_st_done: begin
                if (start) begin
                    w_n_steps  = n_steps;
                    w_step_cnt = '0;
                    w_err_cnt  = '0;
                    w_cyc_cnt  = '0;
                    w_timeout  = 1'b0;
                    if (n_steps == 16'd0) begin
                        w_state    = c_st_report;
                        w_pass     = 1'b1;
                        w_done_req = 1'b1;
                    end else begin
                        w_state = c_st_run;
                        w_pass  = 1'b0;
                    end
                end
            end
            c_st_run: begin
                w_cyc_cnt  = r_cyc_cnt + CYC_W'(1);
                w_step_cnt = w_step_inc;
                w_err_cnt  = w_err_inc;
                // Completion takes priority over budget expiry on the same edge
                if (w_step_inc == r_n_steps) begin
                    w_state    = c_st_report;
                    w_pass     = (w_err_inc == '0);
                    w_timeout  = 1'b0;
                    w_done_req = 1'b1;
                end else if (r_cyc_cnt == c_cyc_last) begin
                    w_state    = c_st_report;
                    w_pass     = 1'b0;
                    w_timeout  = 1'b1;
                    w_done_req = 1'b1;
                end
            end
            c_st_report: begin
                if (done_ack) begin
                    w_state    = c_st_done;
                    w_done_req = 1'b0;
                end
            end
            default: w_state = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_n_steps  <= '0;
            r_step_cnt <= '0;
            r_err_cnt  <= '0;
            r_cyc_cnt  <= '0;
            r_pass     <= 1'b0;
            r_timeout  <= 1'b0;
            r_done_req <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_n_steps  <= w_n_steps;
            r_step_cnt <= w_step_cnt;
            r_err_cnt  <= w_err_cnt;
            r_cyc_cnt  <= w_cyc_cnt;
            r_pass     <= w_pass;
            r_timeout  <= w_timeout;
            r_done_req <= w_done_req;
        end
    end

    assign done_req = r_done_req;
    assign pass     = r_pass;
    assign timeout  = r_timeout;
    assign busy     = (r_state == c_st_run) || (r_state == c_st_report);
    assign err_cnt  = r_err_cnt;
    assign cyc_cnt  = r_cyc_cnt;

endmodule
`default_nettype wire

// File: tb/tb_test_end_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_test_end_responder
// Description : Randomized and directed stimulus for test_end_responder,
//               checked against a behavioural model of the test lifecycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_test_end_responder;

    localparam int CYC_W   = 32;
    localparam int ERR_W   = 2;
    localparam int MAX_CYC = 20;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [15:0]      n_steps = '0;
    logic             step_done = 1'b0;
    logic             step_err = 1'b0;
    logic             done_ack = 1'b0;
    logic             done_req;
    logic             pass;
    logic             timeout;
    logic             busy;
    logic [ERR_W-1:0] err_cnt;
    logic [CYC_W-1:0] cyc_cnt;

    test_end_responder #(.CYC_W(CYC_W), .ERR_W(ERR_W), .MAX_CYC(MAX_CYC)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .n_steps   (n_steps),
        .step_done (step_done),
        .step_err  (step_err),
        .done_req  (done_req),
        .done_ack  (done_ack),
        .pass      (pass),
        .timeout   (timeout),
        .busy      (busy),
        .err_cnt   (err_cnt),
        .cyc_cnt   (cyc_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Behavioural model: where the test is in its lifecycle plus plain counts.
    typedef enum int { PH_IDLE, PH_RUN, PH_REPORT, PH_DONE } phase_t;
    phase_t m_phase = PH_IDLE;
    int     m_target, m_steps, m_errs, m_cycles;
    bit     m_pass, m_timeout;
    int     err_ceiling = (1 << ERR_W) - 1;

    task automatic model_reset();
        m_phase = PH_IDLE; m_target = 0; m_steps = 0; m_errs = 0;
        m_cycles = 0; m_pass = 0; m_timeout = 0;
    endtask

    task automatic model_edge();
        if (rst) begin
            model_reset();
            return;
        end
        if (m_phase == PH_IDLE || m_phase == PH_DONE) begin
            if (start) begin
                m_target = int'(n_steps); m_steps = 0; m_errs = 0;
                m_cycles = 0; m_timeout = 0; m_pass = 0;
                if (m_target == 0) begin
                    m_phase = PH_REPORT; m_pass = 1;
                end else begin
                    m_phase = PH_RUN;
                end
            end
        end else if (m_phase == PH_RUN) begin
            m_cycles++;
            if (step_done) begin
                m_steps++;
                if (step_err && m_errs < err_ceiling) m_errs++;
            end
            if (m_steps == m_target) begin
                m_phase = PH_REPORT; m_pass = (m_errs == 0); m_timeout = 0;
            end else if (m_cycles == MAX_CYC) begin
                m_phase = PH_REPORT; m_pass = 0; m_timeout = 1;
            end
        end else if (done_ack) begin
            m_phase = PH_DONE;
        end
    endtask

    task automatic compare_all();
        chk("done_req", done_req, m_phase == PH_REPORT);
        chk("busy", busy, m_phase == PH_RUN || m_phase == PH_REPORT);
        chk("pass", pass, m_pass);
        chk("timeout", timeout, m_timeout);
        chk("err_cnt", err_cnt, m_errs);
        chk("cyc_cnt", cyc_cnt, m_cycles);
    endtask

    // One clock: drive on the falling edge, update model at the rising edge,
    // sample outputs 1 time unit later.
    task automatic cycle(input logic s, input logic [15:0] n, input logic sd,
                         input logic se, input logic ack);
        @(negedge clk);
        start = s; n_steps = n; step_done = sd; step_err = se; done_ack = ack;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; start = 0; step_done = 0; step_err = 0; done_ack = 0;
        #1;
        chk("async_rst_done_req", done_req, 0);
        chk("async_rst_busy", busy, 0);
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    int hi;

    initial begin
        model_reset();
        apply_reset();

        // Normal pass: three clean steps five cycles apart
        cycle(1, 16'd3, 0, 0, 0);
        for (int i = 1; i <= 11; i++) cycle(0, 0, (i % 5) == 1, 0, 0);
        chk("np_done_req", done_req, 1);
        chk("np_pass", pass, 1);
        chk("np_timeout", timeout, 0);
        chk("np_err_cnt", err_cnt, 0);
        chk("np_cyc_cnt", cyc_cnt, 11);
        hi = int'(done_req);
        for (int k = 0; k < 3; k++) begin
            cycle(0, 0, 0, 0, k == 2);
            hi += int'(done_req);
        end
        chk("np_req_width", hi, 3);
        chk("np_busy_after_ack", busy, 0);

        // Errors with saturation
        cycle(1, 16'd5, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 1, 1, 0);
        chk("sat_err_cnt", err_cnt, 3);
        chk("sat_pass", pass, 0);
        chk("sat_timeout", timeout, 0);
        cycle(0, 0, 0, 0, 1);

        // Timeout: one of four steps completes
        cycle(1, 16'd4, 0, 0, 0);
        for (int i = 1; i <= MAX_CYC; i++) begin
            cycle(0, 0, i == 3, 0, 0);
            if (i == MAX_CYC - 1) chk("to_req_early", done_req, 0);
        end
        chk("to_done_req", done_req, 1);
        chk("to_cyc_cnt", cyc_cnt, MAX_CYC);
        chk("to_pass", pass, 0);
        chk("to_timeout", timeout, 1);
        cycle(0, 0, 0, 0, 1);

        // Completion and budget expiry on the same edge
        cycle(1, 16'd1, 0, 0, 0);
        for (int i = 1; i <= MAX_CYC; i++) cycle(0, 0, i == MAX_CYC, 0, 0);
        chk("sim_pass", pass, 1);
        chk("sim_timeout", timeout, 0);
        chk("sim_done_req", done_req, 1);
        cycle(0, 0, 0, 0, 1);

        // Zero steps, then restart from DONE
        cycle(1, 16'd0, 0, 0, 0);
        chk("zero_done_req", done_req, 1);
        chk("zero_pass", pass, 1);
        cycle(0, 0, 0, 0, 1);
        cycle(1, 16'd2, 0, 0, 0);
        chk("restart_busy", busy, 1);
        chk("restart_err_cnt", err_cnt, 0);
        chk("restart_cyc_cnt", cyc_cnt, 0);
        cycle(0, 0, 1, 1, 0);
        cycle(0, 0, 1, 0, 0);
        chk("restart_done_req", done_req, 1);

        // Reset while the request is open
        apply_reset();
        chk("rst_done_req", done_req, 0);
        chk("rst_cyc_cnt", cyc_cnt, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, i[0]);
        chk("rst_ack_ignored", done_req, 0);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                apply_reset();
            end else begin
                cycle($urandom_range(0, 7) == 0, 16'($urandom_range(0, 12)),
                      $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                      $urandom_range(0, 3) == 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
